// File: rtl/ni_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ni_request_arbiter
//  Description : Round-robin arbiter sharing one network_interface_cdc local
//                memory port among NUM_REQ local masters. Latches the winning
//                request, issues a single-cycle NI strobe, holds the request
//                fields until completion, routes the response back to the
//                owner and flags transactions that never complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module ni_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW            = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*8-1:0]           req_dest_id,
    input  logic [NUM_REQ*3-1:0]           req_msg_type,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [DATA_WIDTH-1:0]          resp_rdata,
    output logic                           mem_write,
    output logic                           mem_read,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic [7:0]                     dest_id,
    output logic [2:0]                     msg_type,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    input  logic                           mem_ready,
    output logic                           busy,
    output logic [GW-1:0]                  grant_id,
    output logic                           timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [GW:0]   c_NUM_REQ = (GW+1)'(NUM_REQ);
    localparam logic [GW-1:0] c_LAST    = GW'(NUM_REQ - 1);
    localparam logic [CW-1:0] c_WD_MAX  = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [GW-1:0]         r_ptr;
    logic [GW-1:0]         r_grant_id;
    logic                  r_hold_write;
    logic [ADDR_WIDTH-1:0] r_hold_addr;
    logic [DATA_WIDTH-1:0] r_hold_wdata;
    logic [7:0]            r_hold_dest;
    logic [2:0]            r_hold_type;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [CW-1:0]         r_wd_cnt;
    logic                  r_timeout_err;

    logic                  w_found;
    logic [GW-1:0]         w_winner;
    logic [GW:0]           w_sum;
    logic [GW-1:0]         w_ptr_next;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [7:0]            w_sel_dest;
    logic [2:0]            w_sel_type;
    logic [CW-1:0]         w_wd_next;

    // Round-robin search from r_ptr; iterating farthest-first lets the
    // closest valid requester overwrite and win.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (GW+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (req_valid[w_sum[GW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[GW-1:0];
            end
        end
    end

    // Field mux for the current winner and the pointer that follows it.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_dest  = '0;
        w_sel_type  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == GW'(i)) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_dest  = req_dest_id[i*8 +: 8];
                w_sel_type  = req_msg_type[i*3 +: 3];
            end
        end
        w_ptr_next = (w_winner == c_LAST) ? '0 : w_winner + GW'(1);
        w_wd_next  = (r_wd_cnt == c_WD_MAX) ? r_wd_cnt : r_wd_cnt + CW'(1);
    end

    // Next-state decode: ISSUE and DONE each last exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_found)   w_state_next = c_ISSUE;
            c_ISSUE:                w_state_next = c_WAIT;
            c_WAIT:  if (mem_ready) w_state_next = c_DONE;
            default:                w_state_next = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture, pointer, response latch and sticky watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr         <= '0;
            r_grant_id    <= '0;
            r_hold_write  <= 1'b0;
            r_hold_addr   <= '0;
            r_hold_wdata  <= '0;
            r_hold_dest   <= '0;
            r_hold_type   <= '0;
            r_resp_rdata  <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_hold_write <= w_sel_write;
                        r_hold_addr  <= w_sel_addr;
                        r_hold_wdata <= w_sel_wdata;
                        r_hold_dest  <= w_sel_dest;
                        r_hold_type  <= w_sel_type;
                        r_grant_id   <= w_winner;
                        r_ptr        <= w_ptr_next;
                    end
                end
                c_ISSUE: begin
                    r_wd_cnt <= '0;
                end
                c_WAIT: begin
                    r_wd_cnt <= w_wd_next;
                    // Flag lands so that it is visible in the TIMEOUT_CYCLES-th
                    // WAIT cycle; completion in that cycle still sets it.
                    if (w_wd_next == c_WD_MAX) begin
                        r_timeout_err <= 1'b1;
                    end
                    if (mem_ready) begin
                        r_resp_rdata <= r_hold_write ? '0 : mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accept and completion strobes; the NI strobes decode straight from flops.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (r_state == c_IDLE && w_found) begin
            req_ready[w_winner] = 1'b1;
        end
        if (r_state == c_DONE) begin
            resp_valid[r_grant_id] = 1'b1;
        end
    end

    assign mem_write   = (r_state == c_ISSUE) &  r_hold_write;
    assign mem_read    = (r_state == c_ISSUE) & ~r_hold_write;
    assign mem_addr    = r_hold_addr;
    assign mem_wdata   = r_hold_wdata;
    assign dest_id     = r_hold_dest;
    assign msg_type    = r_hold_type;
    assign resp_rdata  = r_resp_rdata;
    assign busy        = (r_state != c_IDLE);
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ni_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ni_request_arbiter
//  Description : Randomised self-checking bench for ni_request_arbiter with a
//                transaction-timeline reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_request_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 16;
    localparam int GW = 2;
    localparam int NCYC = 3000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_write, resp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*8-1:0]  req_dest_id;
    logic [N*3-1:0]  req_msg_type;
    logic [DW-1:0]   resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_write, mem_read, mem_ready, busy, timeout_err;
    logic [7:0]      dest_id;
    logic [2:0]      msg_type;
    logic [GW-1:0]   grant_id;

    always #5 clk = ~clk;

    ni_request_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dest_id(req_dest_id),
        .req_msg_type(req_msg_type), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .dest_id(dest_id), .msg_type(msg_type),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one transaction described by its accept cycle t and
    // NI ready cycle m; every output follows from those two numbers.
    bit            m_active;
    int            m_t, m_m, m_owner, m_ptr, m_grant;
    bit            m_write, m_tmo;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [7:0]    m_dest;
    logic [2:0]    m_type;
    bit            pend  [N];
    bit            outst [N];
    int            order [$];
    int            win, idx, d;
    bit            in_wait, did_rst;
    logic [N-1:0]  exp_ready, exp_resp;

    task automatic model_reset();
        m_active = 0; m_ptr = 0; m_grant = 0; m_write = 0; m_tmo = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_dest = '0; m_type = '0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 0;
            outst[i] = 0;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_dest_id = '0; req_msg_type = '0; mem_rdata = '0; mem_ready = 1'b0;
        did_rst = 0;
        model_reset();
        @(posedge clk);
        for (cyc = 0; cyc < NCYC; cyc++) begin
            // ---- drive inputs for this cycle ----
            #1;
            in_wait = m_active && cyc >= m_t + 2 && cyc <= m_m;
            rst = (cyc == 0) ||
                  (!did_rst && cyc >= 1500 && m_active && in_wait && cyc < m_m);
            if (rst && cyc != 0) did_rst = 1;
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i]) begin
                        req_write[i]           = 1'($urandom());
                        req_addr[i*AW +: AW]   = $urandom();
                        req_wdata[i*DW +: DW]  = $urandom();
                        req_dest_id[i*8 +: 8]  = 8'($urandom());
                        req_msg_type[i*3 +: 3] = 3'($urandom());
                        if (!outst[i] && (cyc < 80 || $urandom_range(0, 3) == 0))
                            pend[i] = 1;
                    end else if (cyc >= 80 && $urandom_range(0, 15) == 0) begin
                        pend[i] = 0;
                    end
                end
            end
            for (int i = 0; i < N; i++) req_valid[i] = pend[i];
            mem_rdata = $urandom();
            if (rst)                          mem_ready = 1'b0;
            else if (m_active && cyc == m_m)  mem_ready = 1'b1;
            else if (!in_wait)                mem_ready = 1'($urandom_range(0, 3) == 0);
            else                              mem_ready = 1'b0;

            // ---- check outputs mid-cycle ----
            @(negedge clk);
            win = -1;
            exp_ready = '0;
            if (!m_active) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
                if (win >= 0) exp_ready[win] = 1'b1;
            end
            exp_resp = '0;
            if (m_active && cyc == m_m + 1) exp_resp[m_owner] = 1'b1;
            chk("req_ready",   64'(req_ready),   64'(exp_ready));
            chk("mem_read",    64'(mem_read),    64'(m_active && cyc == m_t + 1 && !m_write));
            chk("mem_write",   64'(mem_write),   64'(m_active && cyc == m_t + 1 && m_write));
            chk("mem_addr",    64'(mem_addr),    64'(m_addr));
            chk("mem_wdata",   64'(mem_wdata),   64'(m_wdata));
            chk("dest_id",     64'(dest_id),     64'(m_dest));
            chk("msg_type",    64'(msg_type),    64'(m_type));
            chk("busy",        64'(busy),        64'(m_active));
            chk("grant_id",    64'(grant_id),    64'(m_grant));
            chk("resp_valid",  64'(resp_valid),  64'(exp_resp));
            chk("resp_rdata",  64'(resp_rdata),  64'(m_rdata));
            chk("timeout_err", 64'(timeout_err), 64'(m_tmo));

            // ---- advance the model across the coming edge ----
            if (rst) begin
                model_reset();
            end else begin
                if (m_active && cyc == m_t + T && m_m >= cyc) m_tmo = 1;
                if (m_active && cyc == m_m) m_rdata = m_write ? '0 : mem_rdata;
                if (m_active && cyc == m_m + 1) begin
                    outst[m_owner] = 0;
                    m_active = 0;
                end
                if (win >= 0) begin
                    m_active = 1; m_t = cyc; m_owner = win; m_grant = win;
                    m_write  = req_write[win];
                    m_addr   = req_addr[win*AW +: AW];
                    m_wdata  = req_wdata[win*DW +: DW];
                    m_dest   = req_dest_id[win*8 +: 8];
                    m_type   = req_msg_type[win*3 +: 3];
                    m_ptr    = (win + 1) % N;
                    pend[win]  = 0;
                    outst[win] = 1;
                    order.push_back(win);
                    if (cyc < 80)                         d = 5;
                    else if ($urandom_range(0, 11) == 0)  d = $urandom_range(13, 20);
                    else                                  d = $urandom_range(1, 6);
                    m_m = cyc + 1 + d;
                end
            end
            @(posedge clk);
        end

        // Contention from reset: every master requesting gives 0,1,2,3,0.
        chk("order_len_ge5", 64'(order.size() >= 5), 64'd1);
        if (order.size() >= 5) begin
            chk("order0", 64'(order[0]), 64'd0);
            chk("order1", 64'(order[1]), 64'd1);
            chk("order2", 64'(order[2]), 64'd2);
            chk("order3", 64'(order[3]), 64'd3);
            chk("order4", 64'(order[4]), 64'd0);
        end
        chk("midwait_rst_done", 64'(did_rst), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
